// File: rtl/matmul_sequencer_if.sv
// matmul_sequencer_if: valid/ready stream that carries C elements to the output stage
interface matmul_sequencer_if #(parameter int DATA_W = 8);
  localparam int ACC_W = 2*DATA_W+2;
  logic [ACC_W-1:0] c_data;
  logic [3:0]       c_index;
  logic             c_valid;
  logic             c_ready;
  modport master(output c_data, c_index, c_valid, input c_ready);
  modport slave(input c_data, c_index, c_valid, output c_ready);
endinterface

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: time-shares one 8x8 MAC to produce the 3x3 product C = A*B in row-major order
module matmul_sequencer #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_done,
  input  logic                  start,
  input  logic [9*DATA_W-1:0]   a_mat,
  input  logic [9*DATA_W-1:0]   b_mat,
  matmul_sequencer_if.master    c_out,
  output logic                  busy,
  output logic                  done
);
  localparam int ACC_W = 2*DATA_W+2;
  typedef enum logic [1:0] {IDLE, MAC, OUT, DONE} state_t;
  state_t            state, state_n;
  logic [1:0]        k, k_n, i, i_n, j, j_n;
  logic [3:0]        idx, idx_n;
  logic [ACC_W-1:0]  acc, acc_n, c_data, c_data_n, sum;
  logic [3:0]        a_sel, b_sel;
  logic [DATA_W-1:0] a_el, b_el;
  logic [2*DATA_W-1:0] prod;
  // Row i and column j are tracked alongside idx so no divide-by-3 is needed.
  always_comb begin
    a_sel = {2'b0, i} * 4'd3 + {2'b0, k};
    b_sel = {2'b0, k} * 4'd3 + {2'b0, j};
    a_el  = a_mat[int'(a_sel)*DATA_W +: DATA_W];
    b_el  = b_mat[int'(b_sel)*DATA_W +: DATA_W];
    prod  = (2*DATA_W)'(a_el) * (2*DATA_W)'(b_el);
    sum   = (k == 2'd0 ? '0 : acc) + ACC_W'(prod);
  end
  always_comb begin
    state_n  = state;
    k_n      = k;
    i_n      = i;
    j_n      = j;
    idx_n    = idx;
    acc_n    = acc;
    c_data_n = c_data;
    case (state)
      IDLE, DONE: if (start && load_done) begin
        state_n = MAC;
        k_n     = '0;
        i_n     = '0;
        j_n     = '0;
        idx_n   = '0;
      end
      MAC: begin
        acc_n = sum;
        k_n   = k == 2'd2 ? 2'd0 : 2'(k + 2'd1);
        if (k == 2'd2) begin
          c_data_n = sum;
          state_n  = OUT;
        end
      end
      OUT: if (c_out.c_ready) begin
        state_n = idx == 4'd8 ? DONE : MAC;
        idx_n   = idx == 4'd8 ? idx : 4'(idx + 4'd1);
        j_n     = idx == 4'd8 ? j : (j == 2'd2 ? 2'd0 : 2'(j + 2'd1));
        i_n     = idx == 4'd8 ? i : (j == 2'd2 ? 2'(i + 2'd1) : i);
        k_n     = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      k      <= '0;
      i      <= '0;
      j      <= '0;
      idx    <= '0;
      acc    <= '0;
      c_data <= '0;
    end else begin
      state  <= state_n;
      k      <= k_n;
      i      <= i_n;
      j      <= j_n;
      idx    <= idx_n;
      acc    <= acc_n;
      c_data <= c_data_n;
    end
  end
  assign c_out.c_data  = c_data;
  assign c_out.c_index = idx;
  assign c_out.c_valid = state == OUT;
  assign busy          = state == MAC || state == OUT;
  assign done          = state == DONE;
endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: random and directed products checked against a loop-based 3x3 matrix model
module tb_matmul_sequencer;
  logic        clk = 0;
  logic        reset, load_done, start;
  logic [71:0] a_mat, b_mat;
  logic        busy, done;
  int          n_checks = 0, n_fail = 0;
  int          cyc = 0;
  matmul_sequencer_if #(.DATA_W(8)) mif();
  matmul_sequencer #(.DATA_W(8)) dut (
    .clk(clk), .reset(reset), .load_done(load_done), .start(start),
    .a_mat(a_mat), .b_mat(b_mat), .c_out(mif.master), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  task automatic run(input int unsigned a[9], input int unsigned b[9],
                     input int stall_idx, input int stall_len, input int pulse_idx, input int rst_idx);
    int unsigned c[9];
    int e0, delay, t;
    for (int r = 0; r < 3; r++)
      for (int s = 0; s < 3; s++) begin
        c[r*3+s] = 0;
        for (int m = 0; m < 3; m++) c[r*3+s] += a[r*3+m] * b[m*3+s];
      end
    for (int p = 0; p < 9; p++) begin
      a_mat[p*8 +: 8] = 8'(a[p]);
      b_mat[p*8 +: 8] = 8'(b[p]);
    end
    @(negedge clk);
    start = 1; load_done = 1; mif.c_ready = 1;
    @(negedge clk);
    start = 0;
    e0 = cyc;
    check("busy_after_start", busy, 1);
    check("done_cleared", done, 0);
    delay = 0;
    for (int n = 0; n < 9; n++) begin
      mif.c_ready = (n == stall_idx || n == rst_idx) ? 0 : 1;
      if (n == pulse_idx) start = 1;
      t = 0;
      while (!mif.c_valid && t < 40) begin
        @(negedge clk);
        start = 0;
        t++;
      end
      start = 0;
      if (!mif.c_valid) begin
        check("valid_timeout", 0, 1);
        return;
      end
      check("valid_cycle", cyc - e0, 3 + 4*n + delay);
      check("c_data", mif.c_data, c[n]);
      check("c_index", mif.c_index, n);
      if (n == rst_idx) begin
        reset = 0;
        @(negedge clk);
        reset = 1;
        mif.c_ready = 1;
        check("rst_c_data", mif.c_data, 0);
        check("rst_c_index", mif.c_index, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (10) begin
          check("rst_no_valid", mif.c_valid, 0);
          @(negedge clk);
        end
        return;
      end
      if (n == stall_idx) begin
        repeat (stall_len) begin
          @(negedge clk);
          check("stall_valid", mif.c_valid, 1);
          check("stall_data", mif.c_data, c[n]);
          check("stall_index", mif.c_index, n);
        end
        delay += stall_len;
        mif.c_ready = 1;
      end
      @(negedge clk);
      check("valid_drop", mif.c_valid, 0);
    end
    check("final_cycle", cyc - e0, 36 + delay);
    check("done_set", done, 1);
    check("busy_clear", busy, 0);
    check("done_index", mif.c_index, 8);
    check("done_data", mif.c_data, c[8]);
  endtask
  initial begin
    int unsigned a[9], b[9];
    reset = 0; load_done = 0; start = 0; a_mat = '0; b_mat = '0; mif.c_ready = 0;
    repeat (3) @(negedge clk);
    check("reset_c_valid", mif.c_valid, 0);
    check("reset_c_data", mif.c_data, 0);
    check("reset_c_index", mif.c_index, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    reset = 1;
    start = 1; load_done = 0;
    repeat (3) @(negedge clk);
    start = 0;
    @(negedge clk);
    check("gated_busy", busy, 0);
    check("gated_valid", mif.c_valid, 0);
    for (int p = 0; p < 9; p++) begin
      a[p] = (p == 0 || p == 4 || p == 8) ? 1 : 0;
      b[p] = p + 1;
    end
    run(a, b, -1, 0, -1, -1);
    for (int p = 0; p < 9; p++) begin a[p] = 255; b[p] = 255; end
    run(a, b, -1, 0, -1, -1);
    for (int p = 0; p < 9; p++) begin a[p] = p + 1; b[p] = 9 - p; end
    run(a, b, 4, 5, 2, -1);
    run(a, b, -1, 0, -1, 3);
    run(a, b, -1, 0, 6, -1);
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < 9; p++) begin
        a[p] = $urandom_range(0, 255);
        b[p] = $urandom_range(0, 255);
      end
      run(a, b, int'($urandom_range(0, 8)), int'($urandom_range(1, 4)), int'($urandom_range(0, 8)), -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
